// File: rtl/io_pad_arbiter.sv
// rtl/io_pad_arbiter.sv - round-robin, lease-limited time-sharing of the user IO pad group
// Optional IO_ARB_PRIORITY_EN: client 0 pre-empts any owner and wins idle arbitration.
module io_pad_arbiter #(
  parameter int NREQ    = 4,
  parameter int NPADS   = 16,
  parameter int LEASE_W = 8,
  parameter int TURN    = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o,
  input  logic [NREQ*NPADS-1:0]   cli_out_i,
  input  logic [NREQ*NPADS-1:0]   cli_oeb_i,
  input  logic [NPADS-1:0]        pad_in_i,
  output logic [NPADS-1:0]        cli_in_o,
  output logic [NPADS-1:0]        pad_out_o,
  output logic [NPADS-1:0]        pad_oeb_o,
  input  logic [LEASE_W-1:0]      lease_max_i,
  output logic [2:0]              owner_o,
  output logic                    busy_o,
  output logic [2:0]              irq_o
);
  localparam int TW = $clog2(TURN + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  state_t state, state_n;

  logic [2:0]         rr_ptr, pick;
  logic [3:0]         sum;
  logic [NREQ-1:0]    req_rot;
  logic [LEASE_W-1:0] lease_cnt;
  logic [TW-1:0]      drain_cnt;
  logic [NPADS-1:0]   own_out, own_oeb;
  logic               found, start, leave, revoke, urgent, rr_keep;
  logic               owner_req, others_req, lease_up, irq_gnt, irq_rev;

  // Rotate requests so bit 0 is the client at rr_ptr, then take the first set bit.
  always_comb begin
    req_rot = NREQ'({req_i, req_i} >> rr_ptr);
    found   = 1'b0;
    pick    = '0;
    sum     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + 4'(i);
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        pick  = sum[2:0];
      end
    end
`ifdef IO_ARB_PRIORITY_EN
    if (req_i[0]) pick = '0;
`endif
  end

  always_comb begin
    own_out = '0;
    own_oeb = '1;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_o[k]) begin
        own_out = cli_out_i[k*NPADS +: NPADS];
        own_oeb = cli_oeb_i[k*NPADS +: NPADS];
      end
    end
  end

  always_comb begin
    owner_req  = |(req_i & gnt_o);
    others_req = |(req_i & ~gnt_o);
    lease_up   = (lease_max_i != '0) && (lease_cnt >= lease_max_i - LEASE_W'(1));
    urgent     = 1'b0;
    rr_keep    = 1'b0;
`ifdef IO_ARB_PRIORITY_EN
    urgent     = (owner_o != 3'd0) && req_i[0];
    rr_keep    = (owner_o == 3'd0);
`endif
    start   = 1'b0;
    leave   = 1'b0;
    revoke  = 1'b0;
    state_n = state;
    case (state)
      IDLE: begin
        if (|req_i) begin
          start   = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // A release on the same edge as a revoke wins, so no revoke pulse.
        if (!owner_req) begin
          leave = 1'b1;
        end else if ((lease_up && others_req) || urgent) begin
          leave  = 1'b1;
          revoke = 1'b1;
        end
        if (leave) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == TW'(TURN - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gnt_o     <= '0;
      owner_o   <= '0;
      rr_ptr    <= '0;
      lease_cnt <= '0;
      drain_cnt <= '0;
      irq_gnt   <= 1'b0;
      irq_rev   <= 1'b0;
      cli_in_o  <= '0;
      pad_out_o <= '0;
      pad_oeb_o <= '1;
    end else begin
      cli_in_o <= pad_in_i;
      irq_gnt  <= start;
      irq_rev  <= revoke;
      if (start) begin
        gnt_o     <= NREQ'(1) << pick;
        owner_o   <= pick;
        lease_cnt <= '0;
      end else if (leave) begin
        gnt_o     <= '0;
        drain_cnt <= '0;
        if (!rr_keep) rr_ptr <= (owner_o == 3'(NREQ - 1)) ? 3'd0 : owner_o + 3'd1;
      end else if (state == GRANT && lease_cnt != '1) begin
        lease_cnt <= lease_cnt + LEASE_W'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + TW'(1);
      if (state == GRANT && !leave) begin
        pad_out_o <= own_out;
        pad_oeb_o <= own_oeb;
      end else begin
        pad_out_o <= '0;
        pad_oeb_o <= '1;
      end
    end
  end

  assign busy_o = (state == GRANT);
  assign irq_o  = {busy_o & others_req, irq_rev, irq_gnt};
endmodule

// File: doc/io_pad_arbiter.md
Name: io_pad_arbiter

Overview:
- Time-shares the 16 user IO pads (io[7:0], io[37:30]) of user_project_wrapper among NREQ internal client engines.
- Uses a round-robin, lease-limited grant; at most one client owns the pads at any time.
- Inserts a tristate turnaround phase between owners.
- Sits between the client engines and the wrapper pad buses, and raises user IRQ pulses on grant and on forced revoke.

Parameters:
- NREQ, 4, number of requesting clients (2..8)
- NPADS, 16, pads in the shared group
- LEASE_W, 8, width of lease counter and lease_max_i
- TURN, 2, turnaround cycles with all pads tristated (>=1)

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_ni  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-client request level; held high while the client wants the pads
- gnt_o  out  NREQ  one-hot grant, registered
- cli_out_i  in  NREQ*NPADS  client pad output values; client k at slice [k*NPADS +: NPADS]
- cli_oeb_i  in  NREQ*NPADS  client pad output enables, active-low, same packing
- pad_in_i  in  NPADS  pad input values from io_in
- cli_in_o  out  NPADS  pad input broadcast to all clients, registered
- pad_out_o  out  NPADS  to io_out
- pad_oeb_o  out  NPADS  to io_oeb
- lease_max_i  in  LEASE_W  maximum owner tenure in cycles while others wait; 0 = unlimited
- owner_o  out  3  index of the current owner; valid only when busy_o=1
- busy_o  out  1  high in GRANT state
- irq_o  out  3  [0] grant pulse, [1] revoke pulse, [2] contention level (req pending while another client owns the pads)

Behaviour:
- Reset (async assert, sync deassert by the clock domain) sets:
  - state=IDLE, gnt_o=0, pad_oeb_o=all 1, pad_out_o=0, cli_in_o=0, irq_o=0, rr_ptr=0, lease_cnt=0, owner_o=0, busy_o=0.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If any req_i bit is set, pick the first set bit at or after rr_ptr, searching cyclically upward with wrap.
  - On the next edge: gnt_o=onehot(k), owner=k, state=GRANT, lease_cnt=0, irq_o[0] high for one cycle.
  - Request sampled in cycle n gives gnt_o in cycle n+1.
- GRANT:
  - pad_out_o/pad_oeb_o are registered copies of the owner's slices, so pads follow the client with 1-cycle latency.
  - The first driven cycle is n+2.
  - lease_cnt increments each cycle and saturates at all-ones.
- GRANT -> DRAIN on either of:
  - Release: owner's req_i=0.
  - Revoke: lease_max_i!=0, lease_cnt>=lease_max_i-1, and any other req_i is set. This also pulses irq_o[1] for one cycle.
- On the transition to DRAIN: gnt_o=0, rr_ptr=owner+1 mod NREQ.
- DRAIN:
  - pad_oeb_o=all 1, pad_out_o=0 for exactly TURN cycles, then IDLE.
  - Arbitration resumes in IDLE, so owner changeover takes TURN+1 cycles from grant drop to the next gnt_o.
- Release and revoke in the same cycle are treated as a release; no irq_o[1].
- A revoked client may keep req_i high. It re-enters arbitration at lowest round-robin priority.
- req_i of non-owners may toggle freely; only levels sampled in IDLE matter.
- cli_in_o = pad_in_i registered every cycle, in all states.
- lease_max_i changes take effect immediately in the comparison.
- Reset mid-GRANT:
  - Pads are tristated asynchronously (pad_oeb_o=1 as soon as wb_rst_ni falls).
  - gnt_o drops immediately.
- Width rules:
  - owner_o zero-extended to 3 bits.
  - Unused slices are ignored when NREQ<8.

Optional Feature:
- Macro: IO_ARB_PRIORITY_EN.
- Enabled:
  - Client 0 is urgent. In GRANT with owner!=0 and req_i[0]=1, the block revokes immediately regardless of lease (irq_o[1] pulses).
  - In IDLE, client 0 wins over the round-robin pick.
  - rr_ptr is not updated after a client-0 tenure.
- Disabled: pure round-robin as above; no added logic.

Test Plan:
- Reset: hold wb_rst_ni=0 with req_i=4'b1111 -> pad_oeb_o=16'hFFFF, gnt_o=0, irq_o=0. Release reset -> gnt_o=4'b0001 one cycle after first sample, irq_o[0] pulses once.
- Single client: req_i[2]=1, cli_out slice 2=16'hA5C3, oeb=0 -> gnt_o=4'b0100 at n+1, pad_out_o=16'hA5C3 at n+2. Drop req -> pad_oeb_o=FFFF for 2 cycles, then IDLE.
- Round robin: req_i=4'b1011 held, each owner releasing after 5 cycles -> grant order 0,1,3,0, with 3 idle cycles between grants (TURN=2).
- Lease revoke: lease_max_i=10, req_i[1] held, req_i[3] rises at cycle 3 -> client 1 is revoked after 10 granted cycles with one irq_o[1] pulse; client 3 is granted after TURN+1 cycles; irq_o[2]=1 while client 3 waits.
- Simultaneous release and revoke on the same edge -> no irq_o[1]; next grant goes normally.
- Async reset in GRANT mid-cycle -> pad_oeb_o=FFFF and gnt_o=0 before the next clock edge. With IO_ARB_PRIORITY_EN: req_i[0] rising during client 2 ownership -> revoke on the next edge and client 0 granted after TURN+1 cycles.
